riscv_decode_stage: RTL and testbench
=====================================

// Module: riscv_decode_stage
// PURPOSE
//  Registered ID stage: full RV32I decode of one instruction per cycle into a control bundle.
//  Sits between the fetch buffer and the EX stage, with valid/ready on both sides.
//  Adds illegal-instruction detection, a flush, a rd==x0 write-enable kill, and an optional
//  skid buffer so the upstream ready_o is registered.
// PARAMETERS
//  DW      32  datapath width; Immediate_o and PC ports are sign/zero-extended to DW
//  EN_SKID 1   1: 2-entry skid, ready_o from a flop; 0: 1 entry, ready_o = !valid_o | ready_i
//  EN_M    0   1: OP opcode with Func7=7'b0000001 (M extension) is legal
// PORTS
//  clk_i          in   1   clock, rising edge
//  rst_i          in   1   reset, asynchronous, active-high
//  Instruction_i  in   32  instruction from fetch
//  Pc_i           in   DW  PC of Instruction_i
//  valid_i        in   1   Instruction_i/Pc_i valid
//  ready_o        out  1   stage can accept this cycle
//  flush_i        in   1   kill all held and incoming instructions
//  ready_i        in   1   EX accepts the output bundle
//  valid_o        out  1   output bundle valid
//  Pc_o           out  DW  PC of the output instruction
//  RegRs1_o/RegRs2_o/RegRd_o  out  5  register fields
//  Func3_o        out  3   function field
//  Func7_o        out  7   function field
//  opcode_o       out  7   opcode field
//  Immediate_o    out  DW  sign-extended immediate
//  Operand1_sel_o out  3   0 reg, 1 PC+4, 2 PC, 3 zero
//  Operand2_sel_o out  3   0 reg, 1 imm, 2 zero
//  RegWr_en_o / memWr_en_o / memRd_en_o  out  1  write-back / store / load enables
//  illegal_o      out  1   instruction not decodable
// BEHAVIOUR
//  Decode is combinational on Instruction_i; the decoded bundle is registered. Latency is 1 cycle
//  from accept to valid_o; throughput is 1 per cycle.
//  Immediates:
//   I (LOAD/OP-IMM/JALR): {sx,i[31:20]}
//   S: {sx,i[31:25],i[11:7]}
//   B: {sx,i[31],i[7],i[30:25],i[11:8],0}
//   U (LUI/AUIPC): {i[31:12],12'b0}
//   J: {sx,i[31],i[19:12],i[20],i[30:21],0}
//   All immediates are sign-extended to exactly DW bits. R-type/other opcodes give 0.
//  Operand selects (op1/op2):
//   JAL, JALR 1/2; AUIPC 2/1; LUI 3/1; LOAD, STORE, OP-IMM 0/1; OP, BRANCH 0/0.
//  RegWr_en_o is 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP, forced to 0 when rd==0.
//  memRd_en_o is 1 for LOAD only; memWr_en_o is 1 for STORE only.
//  illegal_o is 1 for:
//   - an unknown opcode, or i[1:0]!=2'b11
//   - LOAD Func3 not in {0,1,2,4,5}; STORE Func3>2; BRANCH Func3 in {2,3}; JALR Func3!=0
//   - OP Func7 not in {0, 7'h20 (Func3 0/5 only), 7'h01 if EN_M}
//   - OP-IMM shifts with a bad Func7
//   An illegal instruction drives all three enables to 0; the fields and Pc_o still pass through.
//  Handshake: accept = valid_i & ready_o; the output transfers when valid_o & ready_i.
//   Output-side data is stable while valid_o & !ready_i.
//  Skid FSM (EN_SKID=1): EMPTY -> FULL on accept.
//   FULL: accept & !drain -> SKID (new item parked); drain & !accept -> EMPTY; accept & drain stays FULL.
//   SKID: ready_o=0; drain moves skid -> main, back to FULL.
//   ready_o = (state!=SKID), taken from a flop. Ordering is strictly FIFO.
//  flush_i has priority over everything: the next edge returns the FSM to EMPTY with valid_o=0.
//   An item offered in the flush cycle is dropped. ready_o=1 the cycle after a flush.
//  Reset (async, any time): state EMPTY, valid_o=0, ready_o=1, and every bundle output 0.
//   An item in flight is lost.
//  valid_i with ready_o=0 has no effect; upstream holds.
// STRUCTURE
//  define.h gets the opcode constants, the op1/op2 select encodings, and the immediate-type codes.
//  Sub-module riscv_decode_comb: purely combinational Instruction_i -> bundle + illegal.
//   It is instantiated once, ahead of the registers.
//  The top holds the main and skid registers plus the 3-state FSM.
// TESTING
//  - 0xFFF00093 (addi x1,x0,-1) -> next cycle valid_o=1, Immediate_o=0xFFFFFFFF, RegRd_o=1,
//    RegWr_en_o=1, op2_sel=1
//  - 0x123452B7 (lui x5) -> Immediate_o=0x12345000, op1_sel=3, op2_sel=1;
//    0x008000EF (jal x1,+8) -> Immediate_o=8, op1=1, op2=2
//  - 0x0020A223 (sw x2,4(x1)) -> Immediate_o=4, memWr_en_o=1, RegWr_en_o=0;
//    0x00000013 (nop) -> RegWr_en_o=0
//  - 0x00000000, and OP with Func7=0x01 while EN_M=0 -> illegal_o=1 with all enables 0;
//    the same OP with EN_M=1 -> legal
//  - Stream 6 items, ready_i=0 for 3 cycles -> ready_o drops 1 cycle after the skid fills;
//    all 6 emerge in order, none lost or duplicated
//  - flush_i in the SKID state, and rst_i pulsed mid-stream -> valid_o=0 next cycle,
//    ready_o=1, and no stale item emerges afterwards

Source files
------------

// File: rtl/riscv_decode_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_decode_stage_pkg
// Description : Shared RV32I decode definitions: opcode constants, operand
//               select encodings, immediate-type codes, the decoded control
//               bundle type and the immediate assembly helper.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_decode_stage_pkg;

    // RV32I major opcodes
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;

    // Operand 1 select
    localparam logic [2:0] c_OP1_REG  = 3'd0;
    localparam logic [2:0] c_OP1_PC4  = 3'd1;
    localparam logic [2:0] c_OP1_PC   = 3'd2;
    localparam logic [2:0] c_OP1_ZERO = 3'd3;

    // Operand 2 select
    localparam logic [2:0] c_OP2_REG  = 3'd0;
    localparam logic [2:0] c_OP2_IMM  = 3'd1;
    localparam logic [2:0] c_OP2_ZERO = 3'd2;

    // Immediate formats
    localparam logic [2:0] c_IMM_NONE = 3'd0;
    localparam logic [2:0] c_IMM_I    = 3'd1;
    localparam logic [2:0] c_IMM_S    = 3'd2;
    localparam logic [2:0] c_IMM_B    = 3'd3;
    localparam logic [2:0] c_IMM_U    = 3'd4;
    localparam logic [2:0] c_IMM_J    = 3'd5;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [6:0]  opcode;
        logic [31:0] imm;      // 32-bit sign-extended; widened to DW at the port
        logic [2:0]  op1_sel;
        logic [2:0]  op2_sel;
        logic        reg_wr;
        logic        mem_wr;
        logic        mem_rd;
        logic        illegal;
    } decode_t;

    function automatic logic [31:0] gen_imm(input logic [31:0] instr,
                                            input logic [2:0]  imm_type);
        logic [31:0] imm;
        case (imm_type)
            c_IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            c_IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            c_IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            c_IMM_U: imm = {instr[31:12], 12'b0};
            c_IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
        return imm;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_decode_comb.sv
`default_nettype none
// ============================================================================
// Module      : riscv_decode_comb
// Description : Purely combinational RV32I decoder: instruction word to
//               control bundle, including illegal-instruction detection.
//   i_instr : 32-bit instruction word
//   o_dec   : decoded bundle (fields, immediate, selects, enables, illegal)
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_decode_comb
    import riscv_decode_stage_pkg::*;
#(
    parameter bit EN_M = 1'b0
) (
    input  logic [31:0] i_instr,
    output decode_t     o_dec
);

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic [2:0] w_imm_type;
    logic [2:0] w_op1;
    logic [2:0] w_op2;
    logic       w_wr;
    logic       w_mrd;
    logic       w_mwr;
    logic       w_ill;

    assign w_opc = i_instr[6:0];
    assign w_f3  = i_instr[14:12];
    assign w_f7  = i_instr[31:25];

    always_comb begin
        w_imm_type = c_IMM_NONE;
        w_op1      = c_OP1_REG;
        w_op2      = c_OP2_REG;
        w_wr       = 1'b0;
        w_mrd      = 1'b0;
        w_mwr      = 1'b0;
        w_ill      = 1'b0;
        case (w_opc)
            c_OPC_LUI: begin
                w_imm_type = c_IMM_U;
                w_op1      = c_OP1_ZERO;
                w_op2      = c_OP2_IMM;
                w_wr       = 1'b1;
            end
            c_OPC_AUIPC: begin
                w_imm_type = c_IMM_U;
                w_op1      = c_OP1_PC;
                w_op2      = c_OP2_IMM;
                w_wr       = 1'b1;
            end
            c_OPC_JAL: begin
                w_imm_type = c_IMM_J;
                w_op1      = c_OP1_PC4;
                w_op2      = c_OP2_ZERO;
                w_wr       = 1'b1;
            end
            c_OPC_JALR: begin
                w_imm_type = c_IMM_I;
                w_op1      = c_OP1_PC4;
                w_op2      = c_OP2_ZERO;
                w_wr       = 1'b1;
                w_ill      = (w_f3 != 3'd0);
            end
            c_OPC_BRANCH: begin
                w_imm_type = c_IMM_B;
                w_ill      = (w_f3 == 3'd2) || (w_f3 == 3'd3);
            end
            c_OPC_LOAD: begin
                w_imm_type = c_IMM_I;
                w_op2      = c_OP2_IMM;
                w_wr       = 1'b1;
                w_mrd      = 1'b1;
                w_ill      = (w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7);
            end
            c_OPC_STORE: begin
                w_imm_type = c_IMM_S;
                w_op2      = c_OP2_IMM;
                w_mwr      = 1'b1;
                w_ill      = (w_f3 > 3'd2);
            end
            c_OPC_OP_IMM: begin
                w_imm_type = c_IMM_I;
                w_op2      = c_OP2_IMM;
                w_wr       = 1'b1;
                // Only the shifts carry a func7 in the upper immediate bits
                if (w_f3 == 3'd1) begin
                    w_ill = (w_f7 != 7'h00);
                end else if (w_f3 == 3'd5) begin
                    w_ill = (w_f7 != 7'h00) && (w_f7 != 7'h20);
                end
            end
            c_OPC_OP: begin
                w_wr  = 1'b1;
                w_ill = !((w_f7 == 7'h00) ||
                          ((w_f7 == 7'h20) && ((w_f3 == 3'd0) || (w_f3 == 3'd5))) ||
                          ((w_f7 == 7'h01) && EN_M));
            end
            default: begin
                w_ill = 1'b1;
            end
        endcase
        if (i_instr[1:0] != 2'b11) begin
            w_ill = 1'b1;
        end
    end

    always_comb begin
        o_dec         = '0;
        o_dec.rs1     = i_instr[19:15];
        o_dec.rs2     = i_instr[24:20];
        o_dec.rd      = i_instr[11:7];
        o_dec.func3   = w_f3;
        o_dec.func7   = w_f7;
        o_dec.opcode  = w_opc;
        o_dec.imm     = gen_imm(i_instr, w_imm_type);
        o_dec.op1_sel = w_op1;
        o_dec.op2_sel = w_op2;
        // Illegal kills every side effect; a write to x0 is also suppressed
        o_dec.reg_wr  = w_wr && !w_ill && (i_instr[11:7] != 5'd0);
        o_dec.mem_wr  = w_mwr && !w_ill;
        o_dec.mem_rd  = w_mrd && !w_ill;
        o_dec.illegal = w_ill;
    end

endmodule
`default_nettype wire

// File: rtl/riscv_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : riscv_decode_stage
// Description : Registered RV32I ID stage with valid/ready on both sides,
//               flush, and an optional 2-entry skid so ready_o is a flop.
//   clk_i/rst_i            : clock, async active-high reset
//   Instruction_i/Pc_i     : fetch-side item, qualified by valid_i/ready_o
//   flush_i                : drop every held and incoming item
//   ready_i/valid_o        : EX-side handshake
//   Pc_o .. illegal_o      : registered decoded bundle
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_decode_stage
    import riscv_decode_stage_pkg::*;
#(
    parameter int DW      = 32,
    parameter bit EN_SKID = 1'b1,
    parameter bit EN_M    = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [31:0]   Instruction_i,
    input  logic [DW-1:0] Pc_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic          flush_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] Pc_o,
    output logic [4:0]    RegRs1_o,
    output logic [4:0]    RegRs2_o,
    output logic [4:0]    RegRd_o,
    output logic [2:0]    Func3_o,
    output logic [6:0]    Func7_o,
    output logic [6:0]    opcode_o,
    output logic [DW-1:0] Immediate_o,
    output logic [2:0]    Operand1_sel_o,
    output logic [2:0]    Operand2_sel_o,
    output logic          RegWr_en_o,
    output logic          memWr_en_o,
    output logic          memRd_en_o,
    output logic          illegal_o
);

    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_FULL  = 2'd1;
    localparam logic [1:0] c_ST_SKID  = 2'd2;

    decode_t       w_dec;
    logic          w_accept;
    logic          w_drain;

    logic [1:0]    r_state;
    logic          r_valid;
    logic          r_ready;
    decode_t       r_main;
    logic [DW-1:0] r_main_pc;
    decode_t       r_skid;
    logic [DW-1:0] r_skid_pc;

    riscv_decode_comb #(
        .EN_M (EN_M)
    ) u_decode (
        .i_instr (Instruction_i),
        .o_dec   (w_dec)
    );

    assign w_accept = valid_i && ready_o;
    assign w_drain  = r_valid && ready_i;

    generate
        if (EN_SKID) begin : g_skid
            assign ready_o = r_ready;
        end else begin : g_noskid
            // Without the skid a new item may enter only as the old one leaves,
            // so the SKID state is never reached.
            assign ready_o = !r_valid || ready_i;
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= c_ST_EMPTY;
            r_valid   <= 1'b0;
            r_ready   <= 1'b1;
            r_main    <= '0;
            r_main_pc <= '0;
            r_skid    <= '0;
            r_skid_pc <= '0;
        end else if (flush_i) begin
            r_state <= c_ST_EMPTY;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_accept) begin
                        r_main    <= w_dec;
                        r_main_pc <= Pc_i;
                        r_valid   <= 1'b1;
                        r_state   <= c_ST_FULL;
                    end
                end
                c_ST_FULL: begin
                    if (w_accept && w_drain) begin
                        r_main    <= w_dec;
                        r_main_pc <= Pc_i;
                    end else if (w_accept) begin
                        // EX is stalled: park the newcomer behind the main entry
                        r_skid    <= w_dec;
                        r_skid_pc <= Pc_i;
                        r_ready   <= 1'b0;
                        r_state   <= c_ST_SKID;
                    end else if (w_drain) begin
                        r_valid <= 1'b0;
                        r_state <= c_ST_EMPTY;
                    end
                end
                c_ST_SKID: begin
                    if (w_drain) begin
                        r_main    <= r_skid;
                        r_main_pc <= r_skid_pc;
                        r_ready   <= 1'b1;
                        r_state   <= c_ST_FULL;
                    end
                end
                default: begin
                    r_state <= c_ST_EMPTY;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign valid_o        = r_valid;
    assign Pc_o           = r_main_pc;
    assign RegRs1_o       = r_main.rs1;
    assign RegRs2_o       = r_main.rs2;
    assign RegRd_o        = r_main.rd;
    assign Func3_o        = r_main.func3;
    assign Func7_o        = r_main.func7;
    assign opcode_o       = r_main.opcode;
    assign Immediate_o    = DW'($signed(r_main.imm));
    assign Operand1_sel_o = r_main.op1_sel;
    assign Operand2_sel_o = r_main.op2_sel;
    assign RegWr_en_o     = r_main.reg_wr;
    assign memWr_en_o     = r_main.mem_wr;
    assign memRd_en_o     = r_main.mem_rd;
    assign illegal_o      = r_main.illegal;

endmodule
`default_nettype wire

// File: tb/tb_riscv_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_decode_stage
// Description : Directed self-checking bench for riscv_decode_stage: decode
//               vectors, skid streaming, flush and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_decode_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] Instruction_i;
    logic [31:0] Pc_i;
    logic        valid_i;
    logic        flush_i;
    logic        ready_i;

    logic        ready_o, valid_o;
    logic [31:0] Pc_o, Immediate_o;
    logic [4:0]  RegRs1_o, RegRs2_o, RegRd_o;
    logic [2:0]  Func3_o, Operand1_sel_o, Operand2_sel_o;
    logic [6:0]  Func7_o, opcode_o;
    logic        RegWr_en_o, memWr_en_o, memRd_en_o, illegal_o;

    logic        m_ready, m_valid;
    logic [31:0] m_pc, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [2:0]  m_f3, m_op1, m_op2;
    logic [6:0]  m_f7, m_opc;
    logic        m_wr, m_mwr, m_mrd, m_ill;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    riscv_decode_stage #(.DW(32), .EN_SKID(1'b1), .EN_M(1'b0)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .Instruction_i(Instruction_i), .Pc_i(Pc_i),
        .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i), .ready_i(ready_i),
        .valid_o(valid_o), .Pc_o(Pc_o), .RegRs1_o(RegRs1_o), .RegRs2_o(RegRs2_o),
        .RegRd_o(RegRd_o), .Func3_o(Func3_o), .Func7_o(Func7_o), .opcode_o(opcode_o),
        .Immediate_o(Immediate_o), .Operand1_sel_o(Operand1_sel_o),
        .Operand2_sel_o(Operand2_sel_o), .RegWr_en_o(RegWr_en_o),
        .memWr_en_o(memWr_en_o), .memRd_en_o(memRd_en_o), .illegal_o(illegal_o)
    );

    riscv_decode_stage #(.DW(32), .EN_SKID(1'b1), .EN_M(1'b1)) u_dut_m (
        .clk_i(clk_i), .rst_i(rst_i), .Instruction_i(Instruction_i), .Pc_i(Pc_i),
        .valid_i(valid_i), .ready_o(m_ready), .flush_i(flush_i), .ready_i(ready_i),
        .valid_o(m_valid), .Pc_o(m_pc), .RegRs1_o(m_rs1), .RegRs2_o(m_rs2),
        .RegRd_o(m_rd), .Func3_o(m_f3), .Func7_o(m_f7), .opcode_o(m_opc),
        .Immediate_o(m_imm), .Operand1_sel_o(m_op1), .Operand2_sel_o(m_op2),
        .RegWr_en_o(m_wr), .memWr_en_o(m_mwr), .memRd_en_o(m_mrd), .illegal_o(m_ill)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Offer one item with EX ready; on return the item sits on the outputs.
    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        Instruction_i = instr;
        Pc_i          = pc;
        valid_i       = 1'b1;
        ready_i       = 1'b1;
        tick();
        valid_i       = 1'b0;
    endtask

    initial begin : main
        int in_idx;
        int out_idx;
        logic [31:0] s_pc [6];

        rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
        Instruction_i = 32'd0; Pc_i = 32'd0;
        tick(); tick();
        check("rst_valid", valid_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_imm",   Immediate_o, 0);
        check("rst_regwr", RegWr_en_o, 0);
        rst_i = 1'b0;
        tick();

        // addi x1,x0,-1
        present(32'hFFF00093, 32'h0000_0100);
        check("addi_valid", valid_o, 1);
        check("addi_imm",   Immediate_o, 32'hFFFF_FFFF);
        check("addi_rd",    RegRd_o, 1);
        check("addi_wr",    RegWr_en_o, 1);
        check("addi_op2",   Operand2_sel_o, 1);
        check("addi_pc",    Pc_o, 32'h100);
        tick();

        // lui x5,0x12345
        present(32'h123452B7, 32'h104);
        check("lui_imm", Immediate_o, 32'h1234_5000);
        check("lui_op1", Operand1_sel_o, 3);
        check("lui_op2", Operand2_sel_o, 1);
        check("lui_wr",  RegWr_en_o, 1);
        tick();

        // jal x1,+8
        present(32'h008000EF, 32'h108);
        check("jal_imm", Immediate_o, 8);
        check("jal_op1", Operand1_sel_o, 1);
        check("jal_op2", Operand2_sel_o, 2);
        tick();

        // sw x2,4(x1)
        present(32'h0020A223, 32'h10C);
        check("sw_imm",  Immediate_o, 4);
        check("sw_mwr",  memWr_en_o, 1);
        check("sw_wr",   RegWr_en_o, 0);
        check("sw_rs1",  RegRs1_o, 1);
        check("sw_rs2",  RegRs2_o, 2);
        tick();

        // nop: rd==x0 kills the write
        present(32'h00000013, 32'h110);
        check("nop_wr",  RegWr_en_o, 0);
        check("nop_ill", illegal_o, 0);
        tick();

        // beq x1,x2,-4
        present(32'hFE208EE3, 32'h114);
        check("beq_imm", Immediate_o, 32'hFFFF_FFFC);
        check("beq_op1", Operand1_sel_o, 0);
        check("beq_op2", Operand2_sel_o, 0);
        check("beq_wr",  RegWr_en_o, 0);
        tick();

        // all-zero word
        present(32'h00000000, 32'h118);
        check("zero_ill", illegal_o, 1);
        check("zero_en",  {RegWr_en_o, memWr_en_o, memRd_en_o}, 0);
        check("zero_pc",  Pc_o, 32'h118);
        tick();

        // mul x3,x1,x2: illegal without M, legal with M
        present(32'h022081B3, 32'h11C);
        check("mul_ill_noM", illegal_o, 1);
        check("mul_wr_noM",  RegWr_en_o, 0);
        check("mul_ill_M",   m_ill, 0);
        check("mul_wr_M",    m_wr, 1);
        tick();

        // func7=0x20 with func3=1 is not a valid OP
        present(32'h402091B3, 32'h120);
        check("op20_f3_1_ill", illegal_o, 1);
        tick();

        // Stream 6 items with EX stalled for 3 cycles
        for (int k = 0; k < 6; k++) s_pc[k] = 32'h1000 + 32'(4 * k);
        in_idx  = 0;
        out_idx = 0;
        for (int cyc = 0; cyc < 40 && out_idx < 6; cyc++) begin
            ready_i = !(cyc >= 1 && cyc <= 3);
            if (in_idx < 6) begin
                valid_i       = 1'b1;
                Instruction_i = 32'h00000013 | (32'(in_idx + 1) << 7);
                Pc_i          = s_pc[in_idx];
            end else begin
                valid_i = 1'b0;
            end
            if (cyc == 2) begin
                check("stream_ready_low", ready_o, 0);
                check("stream_hold_pc",   Pc_o, s_pc[0]);
            end
            if (valid_o && ready_i) begin
                check("stream_pc", Pc_o, s_pc[out_idx]);
                check("stream_rd", RegRd_o, 5'(out_idx + 1));
                out_idx++;
            end
            if (valid_i && ready_o) in_idx++;
            tick();
        end
        valid_i = 1'b0;
        check("stream_count", out_idx, 6);
        check("stream_no_dup", valid_o, 0);
        tick();

        // Flush while the skid is occupied
        ready_i = 1'b0;
        valid_i = 1'b1; Instruction_i = 32'h00100093; Pc_i = 32'h2000;
        tick();
        Pc_i = 32'h2004;
        tick();
        check("flush_pre_ready", ready_o, 0);
        flush_i = 1'b1; Pc_i = 32'h2008;
        tick();
        flush_i = 1'b0; valid_i = 1'b0;
        check("flush_valid", valid_o, 0);
        check("flush_ready", ready_o, 1);
        ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("flush_no_stale", valid_o, 0);
        end
        present(32'h00100093, 32'h200C);
        check("flush_new_valid", valid_o, 1);
        check("flush_new_pc",    Pc_o, 32'h200C);
        tick();

        // Asynchronous reset mid-stream with the skid occupied
        ready_i = 1'b0;
        valid_i = 1'b1; Instruction_i = 32'hFFF00093; Pc_i = 32'h3000;
        tick();
        Pc_i = 32'h3004;
        tick();
        valid_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        check("arst_valid", valid_o, 0);
        check("arst_ready", ready_o, 1);
        check("arst_pc",    Pc_o, 0);
        check("arst_imm",   Immediate_o, 0);
        #1 rst_i = 1'b0;
        ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("arst_no_stale", valid_o, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
